memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- DLX memory-access stage. Sits directly downstream of the execute/memory pipeline register and upstream of the memory/write-back pipeline register.
- Consumes the registered EX/MEM control and data and performs loads/stores on the data memory through a req/ack handshake. Formats load data by size and sign, and selects the write-back value.
- Stalls the pipeline while an access is outstanding. Reports misaligned accesses and ack time-outs.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- DMEM_ADDR_WIDTH, 18, data-memory word-address width (byte address bits [DMEM_ADDR_WIDTH+1:2]).
- REG_ADDR_WIDTH, 5, register-file address width.
- INSTRUCTION_WIDTH, 32, instruction width; opcode is bits [31:26].
- ACK_TIMEOUT, 255, maximum cycles waiting for dmem_ack; timeout counter width is clog2(ACK_TIMEOUT+1).

Ports:
- clk  in  1  Clock. One clock domain.
- rst_n  in  1  Asynchronous, active-low reset.
- mem_data_rd_en_in  in  1  Load request from EX/MEM.
- mem_data_wr_en_in  in  1  Store request from EX/MEM.
- mem_data_in  in  DATA_WIDTH  Store data.
- alu_data_in  in  DATA_WIDTH  ALU result; byte address for loads and stores.
- reg_wr_en_in  in  1  Register write enable.
- reg_wr_addr_in  in  REG_ADDR_WIDTH  Destination register.
- write_back_mux_sel_in  in  1  1 = write back load data, 0 = write back ALU data.
- instruction_in  in  INSTRUCTION_WIDTH  Instruction; the opcode selects size and sign.
- dmem_req  out  1  Access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DMEM_ADDR_WIDTH  Word address.
- dmem_be  out  4  Byte enables; bit 3 = byte lane [31:24].
- dmem_wdata  out  DATA_WIDTH  Lane-aligned store data.
- dmem_ack  in  1  Access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  DATA_WIDTH  Read word.
- stall  out  1  Freezes all upstream stages.
- wb_data_out  out  DATA_WIDTH  Write-back value to MEM/WB.
- reg_wr_en_out  out  1  Qualified register write enable.
- reg_wr_addr_out  out  REG_ADDR_WIDTH  Pass-through of reg_wr_addr_in.
- misalign_err  out  1  One-cycle pulse: misaligned access.
- bus_err  out  1  One-cycle pulse: ack timeout.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE and the timeout counter clears.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, misalign_err, bus_err = 0.
  - The load-data register clears to 0.
  - Reset mid-access drops dmem_req immediately; any late ack is ignored.
- mem_op = rd_en | wr_en, where both enables are sampled from the EX/MEM inputs. If both are set, the access is a store.
- Sizes by opcode:
  - LB 0x20, LBU 0x24, SB 0x28: byte.
  - LH 0x21, LHU 0x25, SH 0x29: half.
  - Any other opcode: word.
- Alignment: a half access with addr[0]=1 is misaligned; a word access with addr[1:0]≠0 is misaligned.
- Byte lanes are big-endian: byte address 0 maps to lane [31:24].
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, no mem_op: stage is combinational. wb_data_out = alu_data_in, reg_wr_en_out = reg_wr_en_in, stall = 0.
  - IDLE, aligned mem_op: stall = 1 combinationally. On the clock edge, register dmem_* (req=1, we, addr, be, wdata) and go to ACCESS.
  - IDLE, misaligned mem_op: no request is issued. Register a misalign_err pulse and go to DONE, with reg_wr_en_out forced to 0 in DONE.
  - ACCESS: stall = 1; request signals are held stable. The counter increments each cycle without ack.
    - On dmem_ack: register the formatted load data, drop req, go to DONE.
    - If the counter reaches ACK_TIMEOUT without ack: drop req, pulse bus_err, load data = 0, go to DONE.
    - Ack and timeout in the same cycle: ack wins.
  - DONE: stall = 0 and the outputs reflect the completed access; upstream advances at the end of this cycle. DONE always returns to IDLE.
  - Minimum stall for a memory op is 2 cycles (IDLE detect cycle plus at least one ACCESS cycle).
- Load formatting: extract the addressed byte or half. LB and LH sign-extend; LBU and LHU zero-extend; word loads pass through.
- Store formatting:
  - Byte stores replicate the byte to all four lanes with be one-hot.
  - Half stores replicate to both halves with be 1100 or 0011.
  - Word stores use be 1111.
- wb_data_out = write_back_mux_sel_in ? load_data_reg : alu_data_in.
- reg_wr_en_out = reg_wr_en_in & ~error_flag_of_current_op.

Decomposition:
- Shared package dlx_pkg: opcode constants (OP_LB … OP_SW), FSM state encoding, size encoding (SZ_BYTE, SZ_HALF, SZ_WORD).
- One sub-module, mem_align: purely combinational. Computes be, store lane data, misalignment and load extraction/extension. memory_stage holds the FSM, counter and registers.

Test Plan:
- LW, addr 0x100; memory acks after 3 cycles with 0xDEADBEEF:
  - dmem_addr = 0x40, be = 1111.
  - stall high for 4 cycles.
  - DONE: wb_data_out = 0xDEADBEEF, reg_wr_en_out = 1.
- LB at addr 0x103, rdata 0x000000F0 → wb_data_out = 0xFFFFFFF0. The same access as LBU → 0x000000F0.
- SH, data 0x00001234, addr 0x102 → dmem_we = 1, be = 0011, dmem_wdata = 0x12341234. reg_wr_en_out = 0 if reg_wr_en_in = 0.
- LW at addr 0x101 → no dmem_req; misalign_err pulses once; reg_wr_en_out = 0 in DONE; stall lasts 1 cycle.
- LW with dmem_ack never asserted (ACK_TIMEOUT = 4):
  - req high for 4 cycles, then drops.
  - bus_err pulses; wb load data = 0.
  - Return to IDLE.
- ADD (no mem op) → stall = 0, wb_data_out = alu_data_in the same cycle. rst_n pulsed low mid-ACCESS → dmem_req = 0 asynchronously and state = IDLE.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: memory opcodes, memory-stage FSM states and access sizes.
package dlx_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic size_e size_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: size_of = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: size_of = SZ_HALF;
      default:              size_of = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store replication, misalignment and
// load extraction/extension. Big-endian: byte address 0 is lane [31:24].
module mem_align
  import dlx_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] load_data_o
);

  size_e       size;
  logic        zext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size         = size_of(opcode_i);
    zext         = (opcode_i == OP_LBU) || (opcode_i == OP_LHU);
    be_o         = 4'b1111;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    load_data_o  = rdata_i;
    byte_sel     = 8'h00;
    half_sel     = 16'h0000;
    case (size)
      SZ_BYTE: begin
        be_o    = 4'b1000 >> addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
        case (addr_lo_i)
          2'd0:    byte_sel = rdata_i[31:24];
          2'd1:    byte_sel = rdata_i[23:16];
          2'd2:    byte_sel = rdata_i[15:8];
          default: byte_sel = rdata_i[7:0];
        endcase
        load_data_o = zext ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o         = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
        half_sel     = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        load_data_o  = zext ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// DLX memory-access stage: drives the data-memory req/ack port, stalls upstream
// while an access is outstanding, formats loads and selects the write-back value.
module memory_stage
  import dlx_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int DMEM_ADDR_WIDTH   = 18,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ACK_TIMEOUT       = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_data_rd_en_in,
  input  logic                         mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]        mem_data_in,
  input  logic [DATA_WIDTH-1:0]        alu_data_in,
  input  logic                         reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_in,
  input  logic                         write_back_mux_sel_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  output logic                         dmem_req,
  output logic                         dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0]   dmem_addr,
  output logic [3:0]                   dmem_be,
  output logic [DATA_WIDTH-1:0]        dmem_wdata,
  input  logic                         dmem_ack,
  input  logic [DATA_WIDTH-1:0]        dmem_rdata,
  output logic                         stall,
  output logic [DATA_WIDTH-1:0]        wb_data_out,
  output logic                         reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic                         misalign_err,
  output logic                         bus_err,
  output logic [1:0]                   fsm_state_o
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         req_q, req_d;
  logic                         we_q, we_d;
  logic [DMEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]                   be_q, be_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]        load_q, load_d;
  logic                         misalign_q, misalign_d;
  logic                         bus_err_q, bus_err_d;
  logic                         err_q, err_d;
  logic                         stall_c;

  logic                         mem_op;
  logic [3:0]                   be_c;
  logic [DATA_WIDTH-1:0]        wdata_c;
  logic                         misaligned_c;
  logic [DATA_WIDTH-1:0]        load_fmt_c;
  logic                         unused_instr_bits;

  assign mem_op            = mem_data_rd_en_in | mem_data_wr_en_in;
  assign unused_instr_bits = ^instruction_in[INSTRUCTION_WIDTH-7:0];

  // EX/MEM is frozen by stall, so its opcode and address stay valid for the
  // load formatting at ack time without re-registering them.
  mem_align u_align (
    .opcode_i     (instruction_in[INSTRUCTION_WIDTH-1:INSTRUCTION_WIDTH-6]),
    .addr_lo_i    (alu_data_in[1:0]),
    .store_data_i (mem_data_in),
    .rdata_i      (dmem_rdata),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .misaligned_o (misaligned_c),
    .load_data_o  (load_fmt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      load_q     <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      err_q      <= err_d;
    end
  end

  // Handshake: req and its attributes are held stable from issue until the
  // cycle ack is seen (or the wait times out); ack qualifies rdata that cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    err_d      = err_q;
    stall_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          stall_c = 1'b1;
          if (misaligned_c) begin
            misalign_d = 1'b1;
            err_d      = 1'b1;
            load_d     = '0;
            state_d    = ST_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = mem_data_wr_en_in;
            addr_d  = alu_data_in[DMEM_ADDR_WIDTH+1:2];
            be_d    = be_c;
            wdata_d = wdata_c;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        if (dmem_ack) begin
          if (!we_q) load_d = load_fmt_c;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          err_d     = 1'b1;
          load_d    = '0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_be         = be_q;
  assign dmem_wdata      = wdata_q;
  assign stall           = stall_c;
  assign wb_data_out     = write_back_mux_sel_in ? load_q : alu_data_in;
  assign reg_wr_en_out   = reg_wr_en_in & ~err_q;
  assign reg_wr_addr_out = reg_wr_addr_in;
  assign misalign_err    = misalign_q;
  assign bus_err         = bus_err_q;
  assign fsm_state_o     = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: table of complete memory transactions plus
// hand-written reset sequences.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [31:0] mem_data, alu_data;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic        wb_sel;
  logic [31:0] instr;
  logic        dmem_req, dmem_we;
  logic [17:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] wb_data;
  logic        reg_wr_en_o;
  logic [4:0]  reg_wr_addr_o;
  logic        misalign_err, bus_err;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage #(.ACK_TIMEOUT(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mem_data_rd_en_in     (rd_en),
    .mem_data_wr_en_in     (wr_en),
    .mem_data_in           (mem_data),
    .alu_data_in           (alu_data),
    .reg_wr_en_in          (reg_wr_en),
    .reg_wr_addr_in        (reg_wr_addr),
    .write_back_mux_sel_in (wb_sel),
    .instruction_in        (instr),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_be               (dmem_be),
    .dmem_wdata            (dmem_wdata),
    .dmem_ack              (dmem_ack),
    .dmem_rdata            (dmem_rdata),
    .stall                 (stall),
    .wb_data_out           (wb_data),
    .reg_wr_en_out         (reg_wr_en_o),
    .reg_wr_addr_out       (reg_wr_addr_o),
    .misalign_err          (misalign_err),
    .bus_err               (bus_err),
    .fsm_state_o           (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        sel;
    logic        rwe;
    int          ack_after;
    logic [31:0] exp_wb;
    logic        exp_rwe;
    int          exp_stall;
    int          exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [17:0] exp_daddr;
    logic        exp_we;
    logic        exp_mis;
    logic        exp_berr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [5:0] op, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                     input logic sel, input logic rwe, input int ack_after,
                     input logic [31:0] exp_wb, input logic exp_rwe, input int exp_stall,
                     input int exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                     input logic [17:0] exp_daddr, input logic exp_we, input logic exp_mis,
                     input logic exp_berr);
    vec_t v;
    v.name = nm; v.op = op; v.rd = rd; v.wr = wr; v.addr = addr; v.sdata = sdata;
    v.rdata = rdata; v.sel = sel; v.rwe = rwe; v.ack_after = ack_after;
    v.exp_wb = exp_wb; v.exp_rwe = exp_rwe; v.exp_stall = exp_stall; v.exp_req = exp_req;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_daddr = exp_daddr; v.exp_we = exp_we;
    v.exp_mis = exp_mis; v.exp_berr = exp_berr;
    vecs.push_back(v);
  endtask

  // Driver: called just after a rising edge with the stage in IDLE.
  task automatic run_vec(input vec_t v);
    int          stall_cnt = 0;
    int          req_cnt   = 0;
    bit          finished  = 0;
    logic [17:0] cap_addr  = '0;
    logic [3:0]  cap_be    = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_we    = 1'b0;
    instr       = {v.op, 26'h0};
    rd_en       = v.rd;
    wr_en       = v.wr;
    alu_data    = v.addr;
    mem_data    = v.sdata;
    wb_sel      = v.sel;
    reg_wr_en   = v.rwe;
    reg_wr_addr = 5'd7;
    dmem_rdata  = v.rdata;
    dmem_ack    = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (!stall) begin
        finished = 1;
        break;
      end
      stall_cnt++;
      if (dmem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata; cap_we = dmem_we;
        end
      end
      dmem_ack = (dmem_req && v.ack_after != 0 && req_cnt == v.ack_after);
    end
    dmem_ack = 1'b0;
    check({v.name, " finished"}, 32'(finished), 32'd1);
    check({v.name, " stall_cycles"}, stall_cnt, v.exp_stall);
    check({v.name, " req_cycles"}, req_cnt, v.exp_req);
    check({v.name, " wb_data"}, wb_data, v.exp_wb);
    check({v.name, " reg_wr_en"}, 32'(reg_wr_en_o), 32'(v.exp_rwe));
    check({v.name, " reg_wr_addr"}, 32'(reg_wr_addr_o), 32'd7);
    check({v.name, " misalign_err"}, 32'(misalign_err), 32'(v.exp_mis));
    check({v.name, " bus_err"}, 32'(bus_err), 32'(v.exp_berr));
    check({v.name, " req_done"}, 32'(dmem_req), 32'd0);
    if (v.exp_req != 0) begin
      check({v.name, " dmem_addr"}, 32'(cap_addr), 32'(v.exp_daddr));
      check({v.name, " dmem_be"}, 32'(cap_be), 32'(v.exp_be));
      check({v.name, " dmem_wdata"}, cap_wdata, v.exp_wdata);
      check({v.name, " dmem_we"}, 32'(cap_we), 32'(v.exp_we));
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    check({v.name, " back_idle"}, 32'(fsm_state), 32'd0);
    check({v.name, " pulse_clear"}, 32'({misalign_err, bus_err}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; mem_data = '0; alu_data = '0;
    reg_wr_en = 1'b0; reg_wr_addr = '0; wb_sel = 1'b0; instr = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    //  name          op     rd wr addr          sdata         rdata         sel rwe ack  exp_wb        rwe stl req be       wdata         daddr    we mis berr
    add("lw_100",     6'h23, 1, 0, 32'h100,      32'h0,        32'hDEADBEEF, 1, 1,  3,   32'hDEADBEEF, 1,  4,  3,  4'b1111, 32'h0,        18'h40, 0, 0, 0);
    add("lb_103",     6'h20, 1, 0, 32'h103,      32'h0,        32'h000000F0, 1, 1,  1,   32'hFFFFFFF0, 1,  2,  1,  4'b0001, 32'h0,        18'h40, 0, 0, 0);
    add("lbu_103",    6'h24, 1, 0, 32'h103,      32'h0,        32'h000000F0, 1, 1,  1,   32'h000000F0, 1,  2,  1,  4'b0001, 32'h0,        18'h40, 0, 0, 0);
    add("sh_102",     6'h29, 0, 1, 32'h102,      32'h1234,     32'h0,        0, 0,  2,   32'h102,      0,  3,  2,  4'b0011, 32'h12341234, 18'h40, 1, 0, 0);
    add("lw_101_mis", 6'h23, 1, 0, 32'h101,      32'h0,        32'h0,        0, 1,  1,   32'h101,      0,  1,  0,  4'b0000, 32'h0,        18'h0,  0, 1, 0);
    add("add_nomem",  6'h00, 0, 0, 32'h12345678, 32'h0,        32'h0,        0, 1,  0,   32'h12345678, 1,  0,  0,  4'b0000, 32'h0,        18'h0,  0, 0, 0);
    add("lh_202",     6'h21, 1, 0, 32'h202,      32'h0,        32'h12348001, 1, 1,  1,   32'hFFFF8001, 1,  2,  1,  4'b0011, 32'h0,        18'h80, 0, 0, 0);
    add("lhu_200",    6'h25, 1, 0, 32'h200,      32'h0,        32'h80011234, 1, 1,  1,   32'h00008001, 1,  2,  1,  4'b1100, 32'h0,        18'h80, 0, 0, 0);
    add("sb_101",     6'h28, 0, 1, 32'h101,      32'hAB,       32'h0,        0, 0,  1,   32'h101,      0,  2,  1,  4'b0100, 32'hABABABAB, 18'h40, 1, 0, 0);
    add("sw_rdwr",    6'h2B, 1, 1, 32'h104,      32'hCAFEF00D, 32'h0,        0, 1,  1,   32'h104,      1,  2,  1,  4'b1111, 32'hCAFEF00D, 18'h41, 1, 0, 0);
    add("lb_100",     6'h20, 1, 0, 32'h100,      32'h0,        32'h7F000000, 1, 1,  2,   32'h0000007F, 1,  3,  2,  4'b1000, 32'h0,        18'h40, 0, 0, 0);
    add("lw_tmo",     6'h23, 1, 0, 32'h100,      32'h0,        32'h0,        1, 1,  0,   32'h0,        0,  5,  4,  4'b1111, 32'h0,        18'h40, 0, 0, 1);
    add("sh_103_mis", 6'h29, 0, 1, 32'h103,      32'h5555,     32'h0,        0, 1,  1,   32'h103,      0,  1,  0,  4'b0000, 32'h0,        18'h0,  0, 1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_addr", 32'(dmem_addr), 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_errs", 32'({misalign_err, bus_err}), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    wb_sel = 1'b1;
    #1;
    check("rst_load_data", wb_data, 32'd0);
    wb_sel = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of an access, then a late ack
    instr = {6'h23, 26'h0}; rd_en = 1'b1; alu_data = 32'h100; wb_sel = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_req_up", 32'(dmem_req), 32'd1);
    check("mid_state_access", 32'(fsm_state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_drop", 32'(dmem_req), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'd0);
    rd_en = 1'b0;
    dmem_rdata = 32'h11111111;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_state", 32'(fsm_state), 32'd0);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_load", wb_data, 32'd0);
    check("late_ack_stall", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
